// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC affine-point checking datapath:
// default operand width and the checker FSM state encoding.
package ecc_pkg;

    localparam int N = 8;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_M_YY   = 4'd1,
        S_M_XX   = 4'd2,
        S_M_XXX  = 4'd3,
        S_M_AX   = 4'd4,
        S_SUM_AX = 4'd5,
        S_SUM_B  = 4'd6,
        S_CMP    = 4'd7,
        S_DONE   = 4'd8
    } state_e;

endpackage

// File: rtl/mod_mul_serial.sv
// Bit-serial MSB-first modular multiplier: one load cycle, then n
// iterations of acc = (2*acc + bit*opA) mod p. prod is the value of the final step.
module mod_mul_serial
    import ecc_pkg::*;
#(
    parameter int n = N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [n-1:0] opA,
    input  logic [n-1:0] opB,
    input  logic [n-1:0] p,
    output logic         done,
    output logic [n-1:0] prod
);

    localparam int CW = $clog2(n + 1);

    logic [n-1:0]  opa_r;
    logic [n-1:0]  opb_r;
    logic [n-1:0]  p_r;
    logic [n-1:0]  acc_r;
    logic [CW-1:0] cnt_r;
    logic [n-1:0]  step_s;

    // Both reductions are single conditional subtracts; acc < p keeps 2*acc < 2p in n+1 bits.
    function automatic logic [n-1:0] mod_step(
        input logic [n-1:0] acc,
        input logic         b_in,
        input logic [n-1:0] opa,
        input logic [n-1:0] m
    );
        logic [n:0] s;
        s = {acc, 1'b0};
        if (s >= {1'b0, m}) s = s - {1'b0, m};
        else                s = s;
        if (b_in) begin
            s = s + {1'b0, opa};
            if (s >= {1'b0, m}) s = s - {1'b0, m};
            else                s = s;
        end else begin
            s = s;
        end
        return s[n-1:0];
    endfunction

    assign step_s = mod_step(acc_r, opb_r[n-1], opa_r, p_r);
    assign prod   = step_s;
    assign done   = (cnt_r == CW'(1));

    // Operand capture on load, then one MSB-first iteration per cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opa_r <= {n{1'b0}};
            opb_r <= {n{1'b0}};
            p_r   <= {n{1'b0}};
            acc_r <= {n{1'b0}};
            cnt_r <= {CW{1'b0}};
        end else if (load) begin
            opa_r <= opA;
            opb_r <= opB;
            p_r   <= p;
            acc_r <= {n{1'b0}};
            cnt_r <= CW'(n);
        end else if (cnt_r != {CW{1'b0}}) begin
            acc_r <= step_s;
            opb_r <= {opb_r[n-2:0], 1'b0};
            cnt_r <= cnt_r - CW'(1);
        end else begin
            acc_r <= acc_r;
            opb_r <= opb_r;
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/point_on_curve_check.sv
// Checks y^2 == x^3 + a*x + b (mod p) for a captured affine point using one
// shared bit-serial multiplier; infinity and out-of-range points resolve in one cycle.
module point_on_curve_check
    import ecc_pkg::*;
#(
    parameter int n = N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [n-1:0] p,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic [n-1:0] x,
    input  logic [n-1:0] y,
    input  logic         infinity_in,
    output logic         busy,
    output logic         result,
    output logic         on_curve,
    output logic         range_err
);

    state_e       state_r, next_state_s;
    logic [n-1:0] p_r, a_r, b_r, x_r, y_r;
    logic [n-1:0] lhs_r, t_r, u_r;
    logic         loaded_r, busy_r, result_r, on_curve_r, range_err_r;

    logic [n-1:0] nxt_lhs_s, nxt_t_s, nxt_u_s;
    logic         nxt_loaded_s, nxt_on_s, nxt_rng_s, nxt_result_s;
    logic         accept_s, mul_load_s, mul_done_s;
    logic [n-1:0] mul_opa_s, mul_opb_s, mul_prod_s;

    function automatic logic [n-1:0] mod_add(
        input logic [n-1:0] l,
        input logic [n-1:0] r,
        input logic [n-1:0] m
    );
        logic [n:0] s;
        s = {1'b0, l} + {1'b0, r};
        if (s >= {1'b0, m}) s = s - {1'b0, m};
        else                s = s;
        return s[n-1:0];
    endfunction

    function automatic logic is_busy(input state_e s);
        return (s != S_IDLE) && (s != S_DONE);
    endfunction

    assign accept_s  = start && ((state_r == S_IDLE) || (state_r == S_DONE));
    assign busy      = busy_r;
    assign result    = result_r;
    assign on_curve  = on_curve_r;
    assign range_err = range_err_r;

    mod_mul_serial #(.n(n)) u_mul (
        .clk   (clk),
        .reset (reset),
        .load  (mul_load_s),
        .opA   (mul_opa_s),
        .opB   (mul_opb_s),
        .p     (p_r),
        .done  (mul_done_s),
        .prod  (mul_prod_s)
    );

    // Next-state, multiplier sequencing and output next values.
    always_comb begin
        next_state_s = state_r;
        mul_load_s   = 1'b0;
        mul_opa_s    = y_r;
        mul_opb_s    = y_r;
        nxt_loaded_s = loaded_r;
        nxt_lhs_s    = lhs_r;
        nxt_t_s      = t_r;
        nxt_u_s      = u_r;
        nxt_on_s     = on_curve_r;
        nxt_rng_s    = range_err_r;
        nxt_result_s = result_r;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (start) begin
                    nxt_result_s = 1'b0;
                    if (infinity_in) begin
                        next_state_s = S_DONE;
                        nxt_on_s     = 1'b1;
                        nxt_rng_s    = 1'b0;
                    end else if ((x >= p) || (y >= p)) begin
                        next_state_s = S_DONE;
                        nxt_on_s     = 1'b0;
                        nxt_rng_s    = 1'b1;
                    end else begin
                        next_state_s = S_M_YY;
                        nxt_on_s     = 1'b0;
                        nxt_rng_s    = 1'b0;
                    end
                end else if (state_r == S_DONE) begin
                    nxt_result_s = 1'b1;
                end else begin
                    nxt_result_s = 1'b0;
                end
            end
            S_M_YY, S_M_XX, S_M_XXX, S_M_AX: begin
                case (state_r)
                    S_M_YY:  begin mul_opa_s = y_r; mul_opb_s = y_r; end
                    S_M_XX:  begin mul_opa_s = x_r; mul_opb_s = x_r; end
                    S_M_XXX: begin mul_opa_s = t_r; mul_opb_s = x_r; end
                    S_M_AX:  begin mul_opa_s = a_r; mul_opb_s = x_r; end
                    default: begin mul_opa_s = y_r; mul_opb_s = y_r; end
                endcase
                if (!loaded_r) begin
                    mul_load_s   = 1'b1;
                    nxt_loaded_s = 1'b1;
                end else if (mul_done_s) begin
                    nxt_loaded_s = 1'b0;
                    case (state_r)
                        S_M_YY:  begin nxt_lhs_s = mul_prod_s; next_state_s = S_M_XX;   end
                        S_M_XX:  begin nxt_t_s   = mul_prod_s; next_state_s = S_M_XXX;  end
                        S_M_XXX: begin nxt_t_s   = mul_prod_s; next_state_s = S_M_AX;   end
                        S_M_AX:  begin nxt_u_s   = mul_prod_s; next_state_s = S_SUM_AX; end
                        default: begin next_state_s = S_IDLE; end
                    endcase
                end else begin
                    nxt_loaded_s = 1'b1;
                end
            end
            S_SUM_AX: begin
                nxt_t_s      = mod_add(t_r, u_r, p_r);
                next_state_s = S_SUM_B;
            end
            S_SUM_B: begin
                nxt_t_s      = mod_add(t_r, b_r, p_r);
                next_state_s = S_CMP;
            end
            S_CMP: begin
                nxt_on_s     = (lhs_r == t_r);
                nxt_rng_s    = 1'b0;
                nxt_result_s = 1'b1;
                next_state_s = S_DONE;
            end
            default: begin
                next_state_s = S_IDLE;
            end
        endcase
    end

    // State, operand capture and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= S_IDLE;
            p_r         <= {n{1'b0}};
            a_r         <= {n{1'b0}};
            b_r         <= {n{1'b0}};
            x_r         <= {n{1'b0}};
            y_r         <= {n{1'b0}};
            lhs_r       <= {n{1'b0}};
            t_r         <= {n{1'b0}};
            u_r         <= {n{1'b0}};
            loaded_r    <= 1'b0;
            busy_r      <= 1'b0;
            result_r    <= 1'b0;
            on_curve_r  <= 1'b0;
            range_err_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            lhs_r       <= nxt_lhs_s;
            t_r         <= nxt_t_s;
            u_r         <= nxt_u_s;
            loaded_r    <= nxt_loaded_s;
            busy_r      <= is_busy(state_r) && is_busy(next_state_s);
            result_r    <= nxt_result_s;
            on_curve_r  <= nxt_on_s;
            range_err_r <= nxt_rng_s;
            if (accept_s) begin
                p_r <= p;
                a_r <= a;
                b_r <= b;
                x_r <= x;
                y_r <= y;
            end else begin
                p_r <= p_r;
                a_r <= a_r;
                b_r <= b_r;
                x_r <= x_r;
                y_r <= y_r;
            end
        end
    end

endmodule

// File: tb/tb_point_on_curve_check.sv
// Directed bench for point_on_curve_check on the curve y^2 = x^3 + 2x + 2 mod 17,
// with hand-computed membership, latency and busy-duration expectations.
module tb_point_on_curve_check;

    localparam logic [7:0] P17 = 8'd17;
    localparam logic [7:0] A2  = 8'd2;
    localparam logic [7:0] B2  = 8'd2;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] p, a, b, x, y;
    logic       infinity_in;
    logic       busy, result, on_curve, range_err;

    int n_vec = 0;
    int n_err = 0;

    point_on_curve_check #(.n(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .p           (p),
        .a           (a),
        .b           (b),
        .x           (x),
        .y           (y),
        .infinity_in (infinity_in),
        .busy        (busy),
        .result      (result),
        .on_curve    (on_curve),
        .range_err   (range_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one request and follow it to result; optionally disturb inputs mid-check.
    task automatic run_check(input string tag, input logic [7:0] xv, input logic [7:0] yv,
                             input logic inf, input int exp_lat, input int exp_busy,
                             input logic exp_on, input logic exp_rng, input bit disturb);
        int lat;
        int bcnt;
        @(negedge clk);
        x = xv;
        y = yv;
        infinity_in = inf;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_val({tag, "/result_at_accept"}, {31'd0, result}, 32'd0);
        lat  = 0;
        bcnt = 0;
        while (result !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy === 1'b1) bcnt++;
            if (disturb) begin
                if (lat == 5) begin
                    x = 8'd3;
                    y = 8'd3;
                    infinity_in = 1'b1;
                end
                start = (lat == 10) ? 1'b1 : 1'b0;
            end
        end
        start = 1'b0;
        check_val({tag, "/latency"}, lat, exp_lat);
        check_val({tag, "/busy_cycles"}, bcnt, exp_busy);
        check_val({tag, "/on_curve"}, {31'd0, on_curve}, {31'd0, exp_on});
        check_val({tag, "/range_err"}, {31'd0, range_err}, {31'd0, exp_rng});
        check_val({tag, "/busy_at_result"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        p = P17;
        a = A2;
        b = B2;
        x = 8'd0;
        y = 8'd0;
        infinity_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst/busy", {31'd0, busy}, 32'd0);
        check_val("rst/result", {31'd0, result}, 32'd0);
        check_val("rst/on_curve", {31'd0, on_curve}, 32'd0);
        check_val("rst/range_err", {31'd0, range_err}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // (7,6): 36%17=2, (343+14+2)%17=2
        run_check("p76", 8'd7, 8'd6, 1'b0, 39, 38, 1'b1, 1'b0, 1'b0);
        // (6,3) then (5,1) back-to-back from DONE
        run_check("p63", 8'd6, 8'd3, 1'b0, 39, 38, 1'b1, 1'b0, 1'b0);
        run_check("p51", 8'd5, 8'd1, 1'b0, 39, 38, 1'b1, 1'b0, 1'b0);
        // (7,7): lhs 15, rhs 2
        run_check("p77", 8'd7, 8'd7, 1'b0, 39, 38, 1'b0, 1'b0, 1'b0);
        // (0,6): x=0 boundary, rhs = b = 2 = 36%17
        run_check("p06", 8'd0, 8'd6, 1'b0, 39, 38, 1'b1, 1'b0, 1'b0);
        // range errors at x=p and y=p
        run_check("x_eq_p", 8'd17, 8'd3, 1'b0, 1, 0, 1'b0, 1'b1, 1'b0);
        run_check("y_eq_p", 8'd3, 8'd17, 1'b0, 1, 0, 1'b0, 1'b1, 1'b0);
        // point at infinity
        run_check("inf", 8'd0, 8'd0, 1'b1, 1, 0, 1'b1, 1'b0, 1'b0);
        // inputs changed and start pulsed mid-check
        run_check("disturb", 8'd7, 8'd6, 1'b0, 39, 38, 1'b1, 1'b0, 1'b1);
        // in-range point after disturbance restores clean inputs
        run_check("p77b", 8'd7, 8'd7, 1'b0, 39, 38, 1'b0, 1'b0, 1'b0);

        // async reset during a check
        @(negedge clk);
        x = 8'd7;
        y = 8'd6;
        infinity_in = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_val("midrst/busy_before", {31'd0, busy}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_val("midrst/busy", {31'd0, busy}, 32'd0);
        check_val("midrst/result", {31'd0, result}, 32'd0);
        check_val("midrst/on_curve", {31'd0, on_curve}, 32'd0);
        check_val("midrst/range_err", {31'd0, range_err}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("midrst/idle_busy", {31'd0, busy}, 32'd0);
        check_val("midrst/idle_result", {31'd0, result}, 32'd0);
        run_check("post_rst", 8'd7, 8'd6, 1'b0, 39, 38, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
